// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage: owns the PC, drives the instruction memory's combinational
//   read port, and captures {pc, instr} pairs into a 2-entry queue that
//   feeds decode over a valid/ready handshake. A redirect flushes the queue
//   and reloads the PC.
//
//   Optional feature macro: FETCH_ALIGN_CHECK_EN
//     defined   - misaligned redirect target flushes, sets sticky misalign_err
//                 and halts fetch until an aligned redirect arrives.
//     undefined - low two target bits are dropped; misalign_err stays 0.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   imem_address      out    read address (always the current PC)
//   imem_read_write   out    constant 0 (read)
//   imem_data         in     instruction word for imem_address
//   redirect_valid/pc in     load new PC and flush queue
//   out_valid/ready   hs     decode handshake on the queue head
//   out_instr/out_pc  out    queue head contents
//   misalign_err      out    sticky misaligned-redirect flag
module instr_fetch_unit #(
    parameter int                   ADDRWIDTH = 32,
    parameter int                   DATAWIDTH = 32,
    parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ADDRWIDTH-1:0] imem_address,
    output logic                 imem_read_write,
    input  logic [DATAWIDTH-1:0] imem_data,
    input  logic                 redirect_valid,
    input  logic [ADDRWIDTH-1:0] redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_instr,
    output logic [ADDRWIDTH-1:0] out_pc,
    output logic                 misalign_err
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

    localparam logic [ADDRWIDTH-1:0] ALIGN_MASK = {{(ADDRWIDTH-2){1'b1}}, 2'b00};

    state_e                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   pc_q, pc_d;
    logic [1:0]             count_q, count_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   misalign_q, misalign_d;

    // Queue storage is deliberately not reset; count gates its visibility.
    logic [ADDRWIDTH-1:0]   q_pc_q    [2];
    logic [DATAWIDTH-1:0]   q_instr_q [2];

    logic halted, pop, push, misalign_bad;

    assign halted = (state_q == HALT);
    assign pop    = out_valid & out_ready;
    assign push   = !redirect_valid && !halted && ((count_q != 2'd2) || pop);

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign misalign_bad = 1'b0;
`endif

    assign imem_address    = pc_q;
    assign imem_read_write = 1'b0;
    assign out_valid       = (count_q != 2'd0);
    assign out_instr       = q_instr_q[rd_ptr_q];
    assign out_pc          = q_pc_q[rd_ptr_q];
    assign misalign_err    = misalign_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            // Redirect wins over push/pop; any concurrent pop is discarded.
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            if (misalign_bad) begin
                state_d    = HALT;
                misalign_d = 1'b1;
            end else begin
                state_d = RUN;
                pc_d    = redirect_pc & ALIGN_MASK;
            end
        end else begin
            if (pop)
                rd_ptr_d = ~rd_ptr_q;
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
                pc_d     = pc_q + ADDRWIDTH'(4);
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[wr_ptr_q]    <= pc_q;
            q_instr_q[wr_ptr_q] <= imem_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_address, imem_data;
    logic        imem_read_write;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_instr, out_pc;
    logic        misalign_err;

    // Second instance exercising PC wrap from RESET_PC = 0xFFFFFFFC.
    logic [31:0] imem_address2, imem_data2, out_instr2, out_pc2;
    logic        imem_read_write2, out_valid2, misalign_err2;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        case (a)
            32'h0:    return 32'h00940333;
            32'h4:    return 32'h413903b3;
            32'h14:   return 32'h01bd5f33;
            default:  return {a[15:0] ^ 16'h5a5a, ~a[31:16]};
        endcase
    endfunction

    assign imem_data  = imem_f(imem_address);
    assign imem_data2 = imem_f(imem_address2);

    instr_fetch_unit #(.ADDRWIDTH(32), .DATAWIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_address(imem_address), .imem_read_write(imem_read_write),
        .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .misalign_err(misalign_err));

    instr_fetch_unit #(.ADDRWIDTH(32), .DATAWIDTH(32), .RESET_PC(32'hFFFFFFFC)) dut2 (
        .clk(clk), .rst(rst), .imem_address(imem_address2), .imem_read_write(imem_read_write2),
        .imem_data(imem_data2), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2), .out_pc(out_pc2),
        .misalign_err(misalign_err2));

    // Reference model: a queue of fetched {pc, instr} plus fetch PC and flags.
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_halt, m_err;
    int          passed = 0, total = 0;

    task automatic do_reset();
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        mq.delete(); m_pc = 32'h0; m_halt = 1'b0; m_err = 1'b0;
    endtask

    // One clock: drive inputs, compare against the model, advance the model.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        #1;
        total++;
        if (out_valid !== (mq.size() != 0))
            $display("FAIL out_valid got=%0b want=%0b t=%0t", out_valid, mq.size() != 0, $time);
        else passed++;
        if (mq.size() != 0) begin
            total++;
            if (out_pc !== mq[0].pc || out_instr !== mq[0].instr)
                $display("FAIL head got=%h/%h want=%h/%h t=%0t", out_pc, out_instr,
                         mq[0].pc, mq[0].instr, $time);
            else passed++;
        end
        total++;
        if (imem_address !== m_pc)
            $display("FAIL imem_address got=%h want=%h t=%0t", imem_address, m_pc, $time);
        else passed++;
        total++;
        if (misalign_err !== m_err)
            $display("FAIL misalign_err got=%0b want=%0b t=%0t", misalign_err, m_err, $time);
        else passed++;
        if (rv) begin
            mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) begin
                m_halt = 1'b1; m_err = 1'b1;
            end else begin
                m_halt = 1'b0; m_pc = rpc;
            end
`else
            m_pc = {rpc[31:2], 2'b00};
`endif
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (!m_halt && mq.size() < 2) begin
                mq.push_back({m_pc, imem_f(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 1'b0 || misalign_err !== 1'b0 || imem_read_write !== 1'b0)
            $display("FAIL reset_flags got v=%0b e=%0b rw=%0b want=0/0/0",
                     out_valid, misalign_err, imem_read_write);
        else passed++;
        total++;
        if (imem_address !== 32'h0)
            $display("FAIL reset_pc got=%h want=00000000", imem_address);
        else passed++;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
        total++;
        if (imem_address !== 32'h8 || out_pc !== 32'h0 || out_valid !== 1'b1)
            $display("FAIL full_hold got addr=%h pc=%h v=%0b want=00000008/00000000/1",
                     imem_address, out_pc, out_valid);
        else passed++;
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h14, 1'b1);
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL redir_flush got v=%0b want=0", out_valid);
        else passed++;
        cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h14 || out_instr !== 32'h01bd5f33)
            $display("FAIL redir_target got %0b/%h/%h want 1/00000014/01bd5f33",
                     out_valid, out_pc, out_instr);
        else passed++;
        // back-to-back redirects: last one wins
        cycle(1'b1, 32'h40, 1'b1);
        cycle(1'b1, 32'h80, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h80)
            $display("FAIL b2b_redirect got %0b/%h want 1/00000080", out_valid, out_pc);
        else passed++;
        cycle(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (out_valid2 !== 1'b1 || out_pc2 !== 32'hFFFFFFFC || imem_address2 !== 32'h0)
            $display("FAIL wrap_first got %0b/%h addr=%h want 1/fffffffc/00000000",
                     out_valid2, out_pc2, imem_address2);
        else passed++;
        cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (out_valid2 !== 1'b1 || out_pc2 !== 32'h0)
            $display("FAIL wrap_second got %0b/%h want 1/00000000", out_valid2, out_pc2);
        else passed++;
    endtask

    task automatic test_misalign();
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h6, 1'b1);
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL misalign_flush got v=%0b want=0", out_valid);
        else passed++;
        cycle(1'b0, 32'h0, 1'b1);
        total++;
`ifdef FETCH_ALIGN_CHECK_EN
        if (out_valid !== 1'b0 || misalign_err !== 1'b1)
            $display("FAIL misalign_halt got v=%0b e=%0b want 0/1", out_valid, misalign_err);
        else passed++;
`else
        if (out_valid !== 1'b1 || out_pc !== 32'h4 || misalign_err !== 1'b0)
            $display("FAIL misalign_drop got %0b/%h e=%0b want 1/00000004/0",
                     out_valid, out_pc, misalign_err);
        else passed++;
`endif
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h8, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h8)
            $display("FAIL misalign_recover got %0b/%h want 1/00000008", out_valid, out_pc);
        else passed++;
        cycle(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || imem_address !== 32'h0)
            $display("FAIL async_reset got v=%0b addr=%h want 0/00000000", out_valid, imem_address);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); m_pc = 32'h0; m_halt = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_random();
        logic        rv, rdy;
        logic [31:0] rpc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFFFFF8;
                1:       rpc = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
                default: rpc = $urandom_range(0, 255) << 2;
            endcase
            cycle(rv, rpc, rdy);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_misalign();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage sitting directly upstream of the instruction memory and downstream into decode. Owns the program counter, drives the instruction memory's combinational read port, and captures each returned instruction word with its PC into a 2-entry fetch queue. The queue presents instructions to decode over a valid/ready handshake and is flushed on a PC redirect from branch/jump resolution.

## Interface
- ADDRWIDTH, 32, PC and memory address width.
- DATAWIDTH, 32, instruction word width.
- RESET_PC, 32'h0, PC value loaded on reset.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_address  out  ADDRWIDTH  read address to instruction memory; always equals `pc`.
- imem_read_write  out  1  memory read/write select; constant 0 (read only).
- imem_data  in  DATAWIDTH  instruction word returned combinationally for `imem_address`.
- redirect_valid  in  1  one-cycle request to load a new PC and flush the queue.
- redirect_pc  in  ADDRWIDTH  target PC for the redirect.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  DATAWIDTH  instruction word at queue head.
- out_pc  out  ADDRWIDTH  PC of the instruction at queue head.
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- State: `pc`, 2-entry queue of {pc, instr}, read/write pointers, occupancy count 0..2, `halted` flag.
- pop = out_valid & out_ready. push = !redirect_valid & !halted & (count < 2 | pop).
- On push: entry {pc, imem_data} written at tail; pc <= pc + 4, modulo 2^ADDRWIDTH (0xFFFFFFFC wraps to 0x0).
- On redirect_valid: queue emptied (count <= 0, pointers reset), pc <= redirect_pc, no push that cycle; a simultaneous pop is consumed and discarded. Redirect has priority over push and pop.
- Full (count 2) with no pop: no push, pc holds, imem_address stable.
- Full with pop: pop and push both occur, count stays 2.
- Empty: out_valid = 0; out_instr/out_pc hold the stale head contents (don't-care to consumer).
- out_valid = (count != 0); out_instr/out_pc are combinational reads of the head entry.
- States: RUN (halted=0) and HALT (halted=1). HALT entered only via Configuration rule; left only by aligned redirect or reset.

## Timing
- Reset (async assert): pc = RESET_PC, count = 0, out_valid = 0, misalign_err = 0, halted = 0, imem_read_write = 0; queue storage not reset.
- First rising edge after rst deasserts: instruction at RESET_PC pushed; out_valid = 1 after that edge.
- Fetch-to-decode latency 1 cycle; sustained throughput 1 instruction/cycle while out_ready = 1.
- Redirect at edge N: out_valid = 0 during cycle N+1; target instruction visible with out_valid = 1 after edge N+1.
- Reset asserted mid-stream: queue cleared immediately (out_valid falls without waiting for clk).
- Back-to-back redirects: each flushes; last one wins.

## Configuration
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: redirect with redirect_pc[1:0] != 0 flushes queue, sets misalign_err = 1 and halted = 1, pc unchanged; no pushes while halted. A later redirect with aligned target clears halted and loads pc; misalign_err stays 1 until reset.
- Undefined: redirect_pc[1:0] ignored (pc <= {redirect_pc[ADDRWIDTH-1:2], 2'b00}); misalign_err tied 0; halted never set.

## Test plan
- Reset, memory preloaded with 0x00940333 @0x0, 0x413903b3 @0x4, out_ready = 1 -> out_instr/out_pc = 0x00940333/0x0 then 0x413903b3/0x4 on consecutive cycles, out_valid continuous.
- out_ready = 0 for 5 cycles after reset -> count saturates at 2, imem_address holds 0x8, head remains 0x0; raise out_ready -> PCs 0x0, 0x4, 0x8 delivered in order, none lost or duplicated.
- Redirect to 0x14 while queue full and out_ready = 1 -> next cycle out_valid = 0; following cycle out_pc = 0x14, out_instr = 0x01bd5f33.
- RESET_PC = 0xFFFFFFFC -> out_pc sequence 0xFFFFFFFC, 0x00000000.
- Redirect to 0x6 -> with FETCH_ALIGN_CHECK_EN: misalign_err = 1, out_valid stays 0 until redirect to 0x8 delivers out_pc 0x8; without: out_pc = 0x4, misalign_err = 0.
- Assert rst asynchronously mid-cycle with count = 2 -> out_valid drops to 0 before next clk edge; imem_address = RESET_PC.
